// File: rtl/rvfi_chk_pkg.sv
// rtl/rvfi_chk_pkg.sv - shared types and error bit indices for the RVFI commit checker
package rvfi_chk_pkg;

  localparam int ERR_ORDER   = 0;
  localparam int ERR_PC      = 1;
  localparam int ERR_RS1     = 2;
  localparam int ERR_RS2     = 3;
  localparam int ERR_X0      = 4;
  localparam int ERR_TIMEOUT = 5;
  localparam int ERR_HALT    = 6;
  localparam int ERR_ALIGN   = 7;
  localparam int ERR_GAP     = 8;
  localparam int ERR_TRAP    = 9;
  localparam int NUM_ERR     = 10;

  typedef enum logic [1:0] {IDLE, RUN, HALTED, ERROR} state_t;

  // One retire channel's packet, minus the order field whose width is a parameter.
  typedef struct packed {
    logic        valid;
    logic        halt;
    logic        trap;
    logic        load;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic [31:0] rd_wdata;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
  } pkt_t;

endpackage

// File: rtl/rvfi_shadow_regfile.sv
// rtl/rvfi_shadow_regfile.sv - 31x32 shadow register file, NRET prioritised writes, 2*NRET bypassed reads
module rvfi_shadow_regfile #(
  parameter int NRET = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NRET-1:0]        we,
  input  logic [NRET*5-1:0]      waddr,
  input  logic [NRET*32-1:0]     wdata,
  input  logic [2*NRET*5-1:0]    raddr,
  output logic [2*NRET*32-1:0]   rdata
);

  logic [31:0] regs [1:31];
  logic [4:0]  ra;
  logic [31:0] rv;

  // Read ports 0..NRET-1 are rs1, NRET..2*NRET-1 are rs2; port p belongs to channel p%NRET
  // and sees the writes of all older channels in the same cycle.
  always_comb begin
    ra    = '0;
    rv    = '0;
    rdata = '0;
    for (int p = 0; p < 2*NRET; p++) begin
      ra = raddr[p*5 +: 5];
      rv = (ra == 5'd0) ? 32'd0 : regs[ra];
      for (int j = 0; j < p % NRET; j++) begin
        if (we[j] && waddr[j*5 +: 5] == ra && ra != 5'd0) rv = wdata[j*32 +: 32];
      end
      rdata[p*32 +: 32] = rv;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < 32; i++) regs[i] <= '0;
    end else begin
      for (int k = 0; k < NRET; k++) begin
        if (we[k] && waddr[k*5 +: 5] != 5'd0) regs[waddr[k*5 +: 5]] <= wdata[k*32 +: 32];
      end
    end
  end

endmodule

// File: rtl/rvfi_commit_checker.sv
// rtl/rvfi_commit_checker.sv - multi-channel RVFI retirement checker; RVFI_SHADOW_REG_EN enables operand checks
module rvfi_commit_checker
  import rvfi_chk_pkg::*;
#(
  parameter int NRET    = 2,
  parameter int TIMEOUT = 1000,
  parameter int ORDER_W = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NRET-1:0]        commit,
  input  logic [NRET-1:0]        halt,
  input  logic [NRET-1:0]        trap,
  input  logic [NRET*ORDER_W-1:0] order,
  input  logic [NRET*5-1:0]      rs1_addr,
  input  logic [NRET*5-1:0]      rs2_addr,
  input  logic [NRET*32-1:0]     rs1_rdata,
  input  logic [NRET*32-1:0]     rs2_rdata,
  input  logic [NRET-1:0]        load_regfile,
  input  logic [NRET*5-1:0]      rd_addr,
  input  logic [NRET*32-1:0]     rd_wdata,
  input  logic [NRET*32-1:0]     pc_rdata,
  input  logic [NRET*32-1:0]     pc_wdata,
  output logic [15:0]            errcode,
  output logic                   error,
  output logic                   halted,
  output logic [ORDER_W-1:0]     commit_count,
  output logic [ORDER_W-1:0]     first_err_order
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  state_t               state_q, state_n;
  logic [ORDER_W-1:0]   exp_order_q, exp_ord, first_err_q, first_ord, count_q, pop;
  logic [31:0]          exp_pc_q, exp_pc;
  logic                 pc_valid_q, pc_ok, halt_seen, hole_seen, found, timeout_evt;
  logic [WD_W-1:0]      wd_q, wd_n;
  logic [NUM_ERR-1:0]   errcode_q, chk_err, errs, e;
  pkt_t                 pkt [NRET];
  logic [ORDER_W-1:0]   ord [NRET];

  always_comb begin
    for (int k = 0; k < NRET; k++) begin
      pkt[k].valid     = commit[k];
      pkt[k].halt      = halt[k];
      pkt[k].trap      = trap[k];
      pkt[k].load      = load_regfile[k];
      pkt[k].rs1_addr  = rs1_addr[k*5 +: 5];
      pkt[k].rs2_addr  = rs2_addr[k*5 +: 5];
      pkt[k].rd_addr   = rd_addr[k*5 +: 5];
      pkt[k].rs1_rdata = rs1_rdata[k*32 +: 32];
      pkt[k].rs2_rdata = rs2_rdata[k*32 +: 32];
      pkt[k].rd_wdata  = rd_wdata[k*32 +: 32];
      pkt[k].pc_rdata  = pc_rdata[k*32 +: 32];
      pkt[k].pc_wdata  = pc_wdata[k*32 +: 32];
      ord[k]           = order[k*ORDER_W +: ORDER_W];
    end
  end

`ifdef RVFI_SHADOW_REG_EN
  logic [NRET-1:0]      sh_we;
  logic [NRET*5-1:0]    sh_waddr;
  logic [NRET*32-1:0]   sh_wdata;
  logic [2*NRET*5-1:0]  sh_raddr;
  logic [2*NRET*32-1:0] sh_rdata;

  always_comb begin
    for (int k = 0; k < NRET; k++) begin
      sh_we[k]                    = pkt[k].valid && pkt[k].load && pkt[k].rd_addr != 5'd0;
      sh_waddr[k*5 +: 5]          = pkt[k].rd_addr;
      sh_wdata[k*32 +: 32]        = pkt[k].rd_wdata;
      sh_raddr[k*5 +: 5]          = pkt[k].rs1_addr;
      sh_raddr[(NRET+k)*5 +: 5]   = pkt[k].rs2_addr;
    end
  end

  rvfi_shadow_regfile #(.NRET(NRET)) u_shadow (
    .clk   (clk),
    .rst_n (rst),
    .we    (sh_we),
    .waddr (sh_waddr),
    .wdata (sh_wdata),
    .raddr (sh_raddr),
    .rdata (sh_rdata)
  );
`else
  logic unused_shadow;
  always_comb begin
    unused_shadow = 1'b0;
    for (int k = 0; k < NRET; k++)
      unused_shadow = unused_shadow ^ (^{pkt[k].rs1_addr, pkt[k].rs2_addr, pkt[k].rs1_rdata, pkt[k].rs2_rdata});
  end
`endif

  // Channels are walked oldest first so each one sees the order/PC/halt effects of those before it.
  always_comb begin
    exp_ord   = exp_order_q;
    exp_pc    = exp_pc_q;
    pc_ok     = pc_valid_q;
    halt_seen = 1'b0;
    hole_seen = 1'b0;
    found     = 1'b0;
    first_ord = '0;
    chk_err   = '0;
    pop       = '0;
    e         = '0;
    for (int k = 0; k < NRET; k++) begin
      e = '0;
      if (!pkt[k].valid) begin
        hole_seen = 1'b1;
      end else begin
        e[ERR_ORDER] = ord[k] != exp_ord;
        e[ERR_PC]    = pc_ok && (pkt[k].pc_rdata != exp_pc);
`ifdef RVFI_SHADOW_REG_EN
        e[ERR_RS1]   = pkt[k].rs1_rdata != sh_rdata[k*32 +: 32];
        e[ERR_RS2]   = pkt[k].rs2_rdata != sh_rdata[(NRET+k)*32 +: 32];
`endif
        e[ERR_X0]    = pkt[k].load && pkt[k].rd_addr == 5'd0 && pkt[k].rd_wdata != 32'd0;
        e[ERR_HALT]  = (state_q == HALTED) || halt_seen;
        e[ERR_ALIGN] = pkt[k].pc_wdata[1:0] != 2'b00;
        e[ERR_GAP]   = hole_seen;
        e[ERR_TRAP]  = pkt[k].trap;
        if (|e && !found) begin
          found     = 1'b1;
          first_ord = ord[k];
        end
        chk_err   = chk_err | e;
        exp_ord   = exp_ord + ORDER_W'(1);
        exp_pc    = pkt[k].pc_wdata;
        pc_ok     = 1'b1;
        halt_seen = halt_seen | pkt[k].halt;
        pop       = pop + ORDER_W'(1);
      end
    end
  end

  always_comb begin
    wd_n        = wd_q;
    timeout_evt = 1'b0;
    if (state_q == IDLE || state_q == RUN) begin
      if (|commit) begin
        wd_n = '0;
      end else if (wd_q != WD_W'(TIMEOUT)) begin
        wd_n        = wd_q + WD_W'(1);
        timeout_evt = wd_q == WD_W'(TIMEOUT - 1);
      end
    end
    errs              = chk_err;
    errs[ERR_TIMEOUT] = timeout_evt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (timeout_evt) state_n = ERROR;
               else if (|commit) state_n = (|(commit & halt)) ? HALTED : RUN;
      RUN:     if (|(commit & halt)) state_n = HALTED;
               else if (timeout_evt) state_n = ERROR;
      default: state_n = state_q;
    endcase
  end

  always_comb begin
    halted = state_q == HALTED;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_order_q <= '0;
      exp_pc_q    <= '0;
      pc_valid_q  <= 1'b0;
      wd_q        <= '0;
      errcode_q   <= '0;
      count_q     <= '0;
      first_err_q <= '0;
    end else begin
      exp_order_q <= exp_ord;
      exp_pc_q    <= exp_pc;
      pc_valid_q  <= pc_ok;
      wd_q        <= wd_n;
      errcode_q   <= errcode_q | errs;
      count_q     <= count_q + pop;
      if (errcode_q == '0 && errs != '0) first_err_q <= timeout_evt ? count_q : first_ord;
    end
  end

  assign errcode         = {6'b0, errcode_q};
  assign error           = |errcode_q;
  assign commit_count    = count_q;
  assign first_err_order = first_err_q;

endmodule

// File: tb/tb_rvfi_commit_checker.sv
// tb/tb_rvfi_commit_checker.sv - directed scoreboard bench for rvfi_commit_checker
module tb_rvfi_commit_checker;
  import rvfi_chk_pkg::*;

  localparam int NRET = 2;
  localparam int TO   = 10;
  localparam int OW   = 64;
`ifdef RVFI_SHADOW_REG_EN
  localparam logic [15:0] SH = 16'h0004;
`else
  localparam logic [15:0] SH = 16'h0000;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NRET-1:0]    commit, halt, trap, load_regfile;
  logic [NRET*OW-1:0] order;
  logic [NRET*5-1:0]  rs1_addr, rs2_addr, rd_addr;
  logic [NRET*32-1:0] rs1_rdata, rs2_rdata, rd_wdata, pc_rdata, pc_wdata;
  logic [15:0]        errcode;
  logic               error, halted;
  logic [OW-1:0]      commit_count, first_err_order;

  int total = 0;
  int bad   = 0;
  logic [OW-1:0] cnt_model = '0;

  typedef struct {
    string         tag;
    logic [15:0]   err;
    logic [OW-1:0] cnt;
    logic          hlt;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  rvfi_commit_checker #(.NRET(NRET), .TIMEOUT(TO), .ORDER_W(OW)) dut (
    .clk(clk), .rst(rst), .commit(commit), .halt(halt), .trap(trap), .order(order),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_rdata(rs1_rdata), .rs2_rdata(rs2_rdata),
    .load_regfile(load_regfile), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
    .pc_rdata(pc_rdata), .pc_wdata(pc_wdata), .errcode(errcode), .error(error),
    .halted(halted), .commit_count(commit_count), .first_err_order(first_err_order)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    commit = '0; halt = '0; trap = '0; load_regfile = '0; order = '0;
    rs1_addr = '0; rs2_addr = '0; rd_addr = '0;
    rs1_rdata = '0; rs2_rdata = '0; rd_wdata = '0; pc_rdata = '0; pc_wdata = '0;
  endtask

  task automatic set_ch(input int k, input logic [63:0] o, input logic [31:0] pr, input logic [31:0] pw);
    commit[k] = 1'b1;
    order[k*OW +: OW] = o;
    pc_rdata[k*32 +: 32] = pr;
    pc_wdata[k*32 +: 32] = pw;
  endtask

  // Push the expectation for this cycle's packets, clock them in, then pop and compare.
  task automatic cycle(input string tag, input logic [15:0] e, input logic h);
    exp_t x;
    cnt_model = cnt_model + OW'($countones(commit));
    x.tag = tag; x.err = e; x.cnt = cnt_model; x.hlt = h;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk({x.tag, ".errcode"}, 64'(errcode), 64'(x.err));
    chk({x.tag, ".error"}, 64'(error), 64'(|x.err[9:0]));
    chk({x.tag, ".count"}, commit_count, x.cnt);
    chk({x.tag, ".halted"}, 64'(halted), 64'(x.hlt));
    clear_inputs();
  endtask

  // Assert reset mid-cycle; outputs must clear without waiting for a clock edge.
  task automatic do_reset(input string tag);
    #2 rst = 1'b0;
    clear_inputs();
    #1;
    chk({tag, ".rst_errcode"}, 64'(errcode), 64'h0);
    chk({tag, ".rst_halted"}, 64'(halted), 64'h0);
    chk({tag, ".rst_count"}, commit_count, 64'h0);
    chk({tag, ".rst_first"}, first_err_order, 64'h0);
    cnt_model = '0;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    clear_inputs();
    @(posedge clk);
    #1;
    chk("init.error", 64'(error), 64'h0);
    do_reset("init");

    // basic two-channel retire with chaining
    set_ch(0, 0, 32'h0, 32'h4); set_ch(1, 1, 32'h4, 32'h8);
    cycle("t1.c1", 16'h0, 1'b0);
    set_ch(0, 2, 32'h8, 32'hC);
    cycle("t1.c2", 16'h0, 1'b0);
    do_reset("t1");

    // order gap
    set_ch(0, 0, 32'h0, 32'h4); set_ch(1, 1, 32'h4, 32'h8);
    cycle("t2.c1", 16'h0, 1'b0);
    set_ch(0, 3, 32'h8, 32'hC);
    cycle("t2.c2", 16'h0001, 1'b0);
    chk("t2.first", first_err_order, 64'd3);
    do_reset("t2");

    // shadow register bypass, x0 write, same-rd priority
    set_ch(0, 0, 32'h0, 32'h4); load_regfile[0] = 1'b1; rd_addr[4:0] = 5'd5; rd_wdata[31:0] = 32'hDEAD;
    set_ch(1, 1, 32'h4, 32'h8); rs1_addr[9:5] = 5'd5; rs1_rdata[63:32] = 32'hDEAD;
    cycle("t3.bypass_ok", 16'h0, 1'b0);
    set_ch(0, 2, 32'h8, 32'hC); load_regfile[0] = 1'b1; rd_addr[4:0] = 5'd5; rd_wdata[31:0] = 32'hDEAD;
    set_ch(1, 3, 32'hC, 32'h10); rs1_addr[9:5] = 5'd5; rs1_rdata[63:32] = 32'hBEEF;
    cycle("t3.bypass_bad", SH, 1'b0);
    set_ch(0, 4, 32'h10, 32'h14); load_regfile[0] = 1'b1; rd_addr[4:0] = 5'd0; rd_wdata[31:0] = 32'h1;
    set_ch(1, 5, 32'h14, 32'h18); rs1_addr[9:5] = 5'd5; rs1_rdata[63:32] = 32'hDEAD;
    cycle("t3.x0_write", SH | 16'h0010, 1'b0);
    set_ch(0, 6, 32'h18, 32'h1C); load_regfile[0] = 1'b1; rd_addr[4:0] = 5'd7; rd_wdata[31:0] = 32'h1;
    set_ch(1, 7, 32'h1C, 32'h20); load_regfile[1] = 1'b1; rd_addr[9:5] = 5'd7; rd_wdata[63:32] = 32'h2;
    cycle("t3.same_rd", SH | 16'h0010, 1'b0);
    set_ch(0, 8, 32'h20, 32'h24); rs1_addr[4:0] = 5'd7; rs1_rdata[31:0] = 32'h2;
    cycle("t3.rd_winner", SH | 16'h0010, 1'b0);
    chk("t3.first", first_err_order, (SH != 16'h0) ? 64'd3 : 64'd4);
    do_reset("t3");

    // halt on ch0 with a younger commit, then commit while halted
    set_ch(0, 0, 32'h0, 32'h4); halt[0] = 1'b1; set_ch(1, 1, 32'h4, 32'h8);
    cycle("t4.halt", 16'h0040, 1'b1);
    set_ch(0, 2, 32'h8, 32'hC);
    cycle("t4.after", 16'h0040, 1'b1);
    chk("t4.first", first_err_order, 64'd1);
    do_reset("t4");

    // after async reset, first PC is unchecked
    set_ch(0, 0, 32'h100, 32'h104);
    cycle("t6.c1", 16'h0, 1'b0);
    set_ch(0, 1, 32'h104, 32'h108);
    cycle("t6.c2", 16'h0, 1'b0);
    do_reset("t6");

    // non-contiguous vector, PC break, misalignment, trap
    set_ch(0, 0, 32'h0, 32'h4);
    cycle("t7.c1", 16'h0, 1'b0);
    set_ch(1, 1, 32'h4, 32'h8);
    cycle("t7.gap", 16'h0100, 1'b0);
    set_ch(0, 2, 32'h20, 32'h22); trap[0] = 1'b1;
    cycle("t7.multi", 16'h0382, 1'b0);
    chk("t7.first", first_err_order, 64'd1);
    do_reset("t7");

    // watchdog
    set_ch(0, 0, 32'h0, 32'h4);
    cycle("t5.commit", 16'h0, 1'b0);
    for (int i = 1; i < TO; i++) cycle("t5.idle", 16'h0, 1'b0);
    cycle("t5.fire", 16'h0020, 1'b0);
    cycle("t5.sat", 16'h0020, 1'b0);
    chk("t5.first", first_err_order, 64'd1);
    chk("t5.state", 64'(dut.state_q), 64'(ERROR));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rvfi_commit_checker.md
Name: rvfi_commit_checker

Overview:
- Multi-channel RVFI retirement monitor for the pipelined core's verification harness.
- Accepts up to NRET commit packets per cycle and checks order continuity, PC continuity, x0 writes, PC alignment and traps.
- Optionally checks source-operand values against a shadow register file.
- Tracks halt and a commit watchdog, and reports sticky error codes to the testbench.

Parameters:
NRET, 2, retire channels per cycle (1..4); channel 0 is oldest
TIMEOUT, 1000, max consecutive cycles without a commit before a timeout error
ORDER_W, 64, width of order and commit counters

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-low reset
commit  input  NRET  per-channel commit valid
halt  input  NRET  per-channel halt flag, qualified by commit
trap  input  NRET  per-channel trap flag
order  input  NRET*ORDER_W  per-channel instruction order
rs1_addr, rs2_addr  input  NRET*5  source register indices
rs1_rdata, rs2_rdata  input  NRET*32  source register values
load_regfile  input  NRET  rd write enable
rd_addr  input  NRET*5  destination index
rd_wdata  input  NRET*32  destination value
pc_rdata, pc_wdata  input  NRET*32  current PC and next PC
errcode  output  16  sticky error bits
error  output  1  OR of errcode bits 0-9
halted  output  1  halt committed
commit_count  output  ORDER_W  total commits accepted
first_err_order  output  ORDER_W  order of the first erroring packet

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0; expected order 0; expected-PC-valid 0; watchdog 0; state IDLE; shadow regs 0.
- State machine:
  - IDLE: first commit goes to RUN.
  - RUN: committed halt goes to HALTED; timeout goes to ERROR.
  - HALTED: terminal.
  - ERROR: terminal. Checking and counting continue.
- Per cycle, channels are processed in index order with intra-cycle chaining: channel k's expected order, expected PC and shadow view include channels 0..k-1 of the same cycle.
- Errcode bits, set one cycle after the offending commit and sticky until reset:
  - 0: order != expected order (expected +1 per commit).
  - 1: pc_rdata != previous pc_wdata. Not checked for the first commit after reset.
  - 2: rs1_rdata != shadow[rs1_addr].
  - 3: rs2_rdata != shadow[rs2_addr].
  - 4: load_regfile with rd_addr=0 and rd_wdata!=0.
  - 5: watchdog reached TIMEOUT.
  - 6: commit while HALTED, or a commit on a channel above the halting channel in the same cycle.
  - 7: pc_wdata[1:0]!=0.
  - 8: commit vector non-contiguous (a valid channel above an invalid one); those packets are still checked.
  - 9: trap=1.
  - 10-15: 0.
- Shadow reads of x0 return 0. Writes with rd_addr=0 are discarded.
- Same-cycle same-rd writes: the highest channel wins.
- Watchdog:
  - Counts cycles with no commit in IDLE and RUN; resets to 0 on any commit.
  - Saturates at TIMEOUT; sets bit 5 once.
  - Frozen in HALTED.
- commit_count adds popcount(commit) each cycle and wraps at 2^ORDER_W.
- first_err_order: captured on the 0-to-nonzero transition of errcode. Uses the lowest erroring channel's order; uses commit_count for timeout. Unchanged afterwards.
- Multiple errors in one cycle set all relevant bits.
- halted is registered: 1 the cycle after the halt commit.

Optional Feature:
- Macro RVFI_SHADOW_REG_EN.
- Defined: 31x32 shadow register file; bits 2 and 3 are active.
- Undefined: no shadow storage; bits 2 and 3 are tied to 0; all other behaviour is identical.

Decomposition:
- Package rvfi_chk_pkg holds:
  - errcode bit index localparams (ERR_ORDER=0 … ERR_TRAP=9);
  - state enum {IDLE, RUN, HALTED, ERROR};
  - a typedef struct for one unpacked commit packet.
- Sub-module rvfi_shadow_regfile: 31x32 storage, NRET write ports with priority and 2*NRET combinational read ports with intra-cycle bypass. Instantiated only under RVFI_SHADOW_REG_EN.

Test Plan:
1. NRET=2; ch0 order 0 pc 0x0→0x4, ch1 order 1 pc 0x4→0x8, then next cycle order 2 pc 0x8 → errcode=0, commit_count=3.
2. Order sequence 0,1,3 → errcode bit0 set 1 cycle after the third commit; first_err_order=3; error=1.
3. Same cycle: ch0 writes x5=0xDEAD, ch1 reads rs1=x5 with 0xDEAD → no error. Repeat with 0xBEEF → bit2 set. With the macro undefined → bit2 stays 0.
4. Halt on ch0 with ch1 also committing → halted=1, bit6 set. A further commit next cycle → bit6 remains, commit_count still increments.
5. TIMEOUT=10; one commit, then 10 idle cycles → bit5 set, state ERROR, first_err_order=1.
6. Drive rst=0 asynchronously mid-cycle after errors → errcode, halted and commit_count read 0 immediately. First commit after release has pc_rdata unchecked.
